// File: rtl/png_chunk_wrap_if.sv
// Signal bundle around png_chunk_wrap: chunk request, input/output word
// streams and the crc32_core side channel. Names keep the DUT-relative _i/_o view.
interface png_chunk_wrap_if #(
    parameter int DATA_WD = 32,
    parameter int LEN_WD  = 32
);
    logic               start_i;
    logic               start_rdy_o;
    logic [LEN_WD-1:0]  len_i;
    logic [31:0]        typ_i;
    logic               val_i;
    logic [DATA_WD-1:0] dat_i;
    logic               rdy_o;
    logic               val_o;
    logic [DATA_WD-1:0] dat_o;
    logic               lst_o;
    logic               rdy_i;
    logic               err_o;
    logic               crc_start_o;
    logic               crc_val_o;
    logic [31:0]        crc_dat_o;
    logic               crc_lst_o;
    logic               crc_done_i;
    logic               crc_val_i;
    logic [31:0]        crc_dat_i;

    modport slave (
        input  start_i, len_i, typ_i, val_i, dat_i, rdy_i,
               crc_done_i, crc_val_i, crc_dat_i,
        output start_rdy_o, rdy_o, val_o, dat_o, lst_o, err_o,
               crc_start_o, crc_val_o, crc_dat_o, crc_lst_o
    );

    modport master (
        output start_i, len_i, typ_i, val_i, dat_i, rdy_i,
               crc_done_i, crc_val_i, crc_dat_i,
        input  start_rdy_o, rdy_o, val_o, dat_o, lst_o, err_o,
               crc_start_o, crc_val_o, crc_dat_o, crc_lst_o
    );
endinterface

// File: rtl/png_chunk_wrap.sv
// Frames one PNG chunk as length, type, data words and CRC word, feeding the
// type and data words to an external crc32_core exactly once each.
module png_chunk_wrap #(
    parameter int DATA_WD = 32,
    parameter int LEN_WD  = 32
) (
    input  logic             clk,
    input  logic             rst,
    png_chunk_wrap_if.slave  bus
);
    localparam int CNT_WD = LEN_WD - 2;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_LEN, S_TYP, S_DAT, S_WAIT, S_CRCO
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_WD-1:0]   len_q, len_d;
    logic [31:0]         typ_q, typ_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;
    logic [31:0]         crc_q, crc_d;
    logic                err_q, err_d;
    logic                crc_val_q, crc_val_d;
    logic [31:0]         crc_dat_q, crc_dat_d;
    logic                crc_lst_q, crc_lst_d;

    // crc32_core completion is informational; the result strobe is crc_val_i.
    logic unused_done;
    assign unused_done = bus.crc_done_i;

    // NOTE: every register, including the captured header and CRC, is cleared
    // by reset so an aborted chunk leaves nothing behind for the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            typ_q     <= '0;
            cnt_q     <= '0;
            crc_q     <= '0;
            err_q     <= 1'b0;
            crc_val_q <= 1'b0;
            crc_dat_q <= '0;
            crc_lst_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            state_q   <= state_d;
            len_q     <= len_d;
            typ_q     <= typ_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            err_q     <= err_d;
            crc_val_q <= crc_val_d;
            crc_dat_q <= crc_dat_d;
            crc_lst_q <= crc_lst_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d   = state_q;
        len_d     = len_q;
        typ_d     = typ_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        err_d     = 1'b0;
        crc_val_d = 1'b0;
        crc_dat_d = '0;
        crc_lst_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (bus.len_i[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = bus.len_i;
                        typ_d   = bus.typ_i;
                        cnt_d   = bus.len_i[LEN_WD-1:2];
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: state_d = S_LEN;
            S_LEN: begin
                if (bus.rdy_i) state_d = S_TYP;
            end
            S_TYP: begin
                // The type word enters the CRC only once it has left downstream.
                if (bus.rdy_i) begin
                    crc_val_d = 1'b1;
                    crc_dat_d = typ_q;
                    crc_lst_d = (cnt_q == '0);
                    state_d   = (cnt_q == '0) ? S_WAIT : S_DAT;
                end
            end
            S_DAT: begin
                if (bus.val_i && bus.rdy_i) begin
                    crc_val_d = 1'b1;
                    crc_dat_d = 32'(bus.dat_i);
                    crc_lst_d = (cnt_q == CNT_WD'(1));
                    cnt_d     = cnt_q - CNT_WD'(1);
                    if (cnt_q == CNT_WD'(1)) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.crc_val_i) begin
                    crc_d   = bus.crc_dat_i;
                    state_d = S_CRCO;
                end
            end
            S_CRCO: begin
                if (bus.rdy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.start_rdy_o = (state_q == S_IDLE);
        bus.crc_start_o = (state_q == S_INIT);
        bus.rdy_o       = 1'b0;
        bus.val_o       = 1'b0;
        bus.dat_o       = '0;
        bus.lst_o       = 1'b0;
        unique case (state_q)
            S_LEN: begin
                bus.val_o = 1'b1;
                bus.dat_o = DATA_WD'(len_q);
            end
            S_TYP: begin
                bus.val_o = 1'b1;
                bus.dat_o = DATA_WD'(typ_q);
            end
            S_DAT: begin
                bus.rdy_o = bus.rdy_i;
                bus.val_o = bus.val_i;
                bus.dat_o = bus.dat_i;
            end
            S_CRCO: begin
                bus.val_o = 1'b1;
                bus.lst_o = 1'b1;
                bus.dat_o = DATA_WD'(crc_q);
            end
            default: ;
        endcase
    end

    assign bus.err_o     = err_q;
    assign bus.crc_val_o = crc_val_q;
    assign bus.crc_dat_o = crc_dat_q;
    assign bus.crc_lst_o = crc_lst_q;
endmodule

// File: tb/tb_png_chunk_wrap.sv
// Randomized bench for png_chunk_wrap: a queue-based model of the chunk word
// stream and CRC feed, plus a behavioural crc32_core stand-in.
module tb_png_chunk_wrap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    png_chunk_wrap_if #(.DATA_WD(32), .LEN_WD(32)) bus ();
    png_chunk_wrap #(.DATA_WD(32), .LEN_WD(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] dat; logic lst; } word_t;
    word_t out_q[$];
    word_t feed_q[$];
    logic [31:0] none[$];

    int n_tests = 0, n_fail = 0;
    int rdy_mode = 0;
    int cyc = 0, crc_val_cnt = 0, crc_start_cnt = 0, err_cnt = 0, val_cnt = 0;
    int start_acc_cnt = 0, start_gap = 0, last_crc_cyc = -100;
    int xfer_cnt = 0, lst_cnt = 0;
    logic dat_acc = 1'b0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        c = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) c = crc_byte(c, w[i*8 +: 8]);
        return c;
    endfunction

    function automatic logic [31:0] chunk_crc(input logic [31:0] typ, input logic [31:0] d[$]);
        logic [31:0] c;
        c = crc_word(32'hFFFFFFFF, typ);
        foreach (d[i]) c = crc_word(c, d[i]);
        return ~c;
    endfunction

    task automatic push_chunk(input logic [31:0] typ, input logic [31:0] d[$]);
        int n = d.size();
        out_q.push_back('{32'(n * 4), 1'b0});
        out_q.push_back('{typ, 1'b0});
        feed_q.push_back('{typ, n == 0});
        foreach (d[i]) begin
            out_q.push_back('{d[i], 1'b0});
            feed_q.push_back('{d[i], i == n - 1});
        end
        out_q.push_back('{chunk_crc(typ, d), 1'b1});
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_start_rdy"}, 32'(bus.start_rdy_o), 1);
        check({tag, "_rdy"},       32'(bus.rdy_o), 0);
        check({tag, "_val"},       32'(bus.val_o), 0);
        check({tag, "_dat"},       bus.dat_o, 0);
        check({tag, "_lst"},       32'(bus.lst_o), 0);
        check({tag, "_err"},       32'(bus.err_o), 0);
        check({tag, "_crc_start"}, 32'(bus.crc_start_o), 0);
        check({tag, "_crc_val"},   32'(bus.crc_val_o), 0);
        check({tag, "_crc_dat"},   bus.crc_dat_o, 0);
        check({tag, "_crc_lst"},   32'(bus.crc_lst_o), 0);
    endtask

    // Downstream ready pattern: always, alternating, or random.
    initial begin
        bus.rdy_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.rdy_i = 1'b1;
                1:       bus.rdy_i = ~bus.rdy_i;
                default: bus.rdy_i = ($urandom % 4) != 0;
            endcase
        end
    end

    // crc32_core stand-in: accumulates fed words and answers after a short delay.
    initial begin : crc_emu
        logic [31:0] c;
        int dly;
        c = '0;
        dly = 0;
        bus.crc_val_i = 1'b0;
        bus.crc_done_i = 1'b0;
        bus.crc_dat_i = '0;
        forever begin
            @(negedge clk);
            bus.crc_val_i = 1'b0;
            bus.crc_done_i = 1'b0;
            if (rst) begin
                dly = 0;
            end else begin
                if (bus.crc_start_o) c = 32'hFFFFFFFF;
                if (bus.crc_val_o) begin
                    c = crc_word(c, bus.crc_dat_o);
                    if (bus.crc_lst_o) dly = 1 + int'($urandom % 3);
                end else if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        bus.crc_val_i = 1'b1;
                        bus.crc_done_i = 1'b1;
                        bus.crc_dat_i = ~c;
                    end
                end
            end
        end
    end

    // Compare process: every output transfer and CRC feed against the model.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                dat_acc = 1'b0;
            end else begin
                cyc++;
                dat_acc = bus.val_i && bus.rdy_o;
                if (bus.start_i && bus.start_rdy_o) begin
                    start_acc_cnt++;
                    start_gap = cyc - last_crc_cyc;
                end
                if (bus.err_o) err_cnt++;
                if (bus.crc_start_o) crc_start_cnt++;
                if (bus.val_o) val_cnt++;
                if (bus.crc_val_o) begin
                    crc_val_cnt++;
                    if (feed_q.size() == 0) check("crc_feed_extra", 32'(bus.crc_val_o), 0);
                    else begin
                        w = feed_q.pop_front();
                        check("crc_feed_dat", bus.crc_dat_o, w.dat);
                        check("crc_feed_lst", 32'(bus.crc_lst_o), 32'(w.lst));
                    end
                end
                if (bus.val_o && prev_stall) check("stall_hold", bus.dat_o, prev_dat);
                if (prev_stall && !bus.val_o) check("stall_val_drop", 32'(bus.val_o), 1);
                if (bus.val_o && bus.rdy_i) begin
                    xfer_cnt++;
                    if (bus.lst_o) begin
                        lst_cnt++;
                        last_crc_cyc = cyc;
                    end
                    if (out_q.size() == 0) check("out_extra_word", bus.dat_o, 32'hDEADDEAD);
                    else begin
                        w = out_q.pop_front();
                        check("out_dat", bus.dat_o, w.dat);
                        check("out_lst", 32'(bus.lst_o), 32'(w.lst));
                    end
                end
                prev_stall = bus.val_o && !bus.rdy_i;
                prev_dat = bus.dat_o;
            end
        end
    end

    task automatic wait_drain();
        int guard = 0;
        while ((out_q.size() != 0 || !bus.start_rdy_o) && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_timeout", 32'(guard < 2000), 1);
        check("feed_left", 32'(feed_q.size()), 0);
    endtask

    // One chunk; gap adds val_i bubbles; abort_at >= 0 resets after that many data words.
    task automatic run_chunk(input logic [31:0] typ, input logic [31:0] d[$],
                             input int gap, input int abort_at);
        int nw = d.size();
        int base_val = crc_val_cnt, base_start = crc_start_cnt;
        int idx = 0, guard = 0;
        push_chunk(typ, d);
        while (!bus.start_rdy_o && guard < 200) begin @(posedge clk); #1; guard++; end
        bus.start_i = 1'b1;
        bus.len_i = 32'(nw * 4);
        bus.typ_i = typ;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        guard = 0;
        forever begin
            if (dat_acc) idx++;
            if (idx == abort_at || idx >= nw || guard >= 2000) break;
            if (!bus.val_i || dat_acc) begin
                bus.val_i = (gap == 0) || (($urandom % 3) != 0);
                bus.dat_i = d[idx];
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.val_i = 1'b0;
        check("data_timeout", 32'(guard < 2000), 1);
        if (idx == abort_at) begin
            rst = 1'b1;
            #1;
            check_reset_outs("abort");
            out_q.delete();
            feed_q.delete();
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            wait_drain();
            check("crc_val_pulses", 32'(crc_val_cnt - base_val), 32'(nw + 1));
            check("crc_start_pulses", 32'(crc_start_cnt - base_start), 1);
        end
    endtask

    initial begin
        logic [31:0] d[$];
        logic [31:0] c;
        int base_err, base_start, base_val, base_x, base_l, guard;
        bus.start_i = 1'b0;
        bus.len_i = '0;
        bus.typ_i = '0;
        bus.val_i = 1'b0;
        bus.dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b0;

        // Pin the reference CRC with known values.
        check("pin_crc_iend", chunk_crc(32'h49454E44, none), 32'hAE426082);
        c = crc_word(32'hFFFFFFFF, 32'h31323334);
        c = crc_word(c, 32'h35363738);
        c = ~crc_byte(c, 8'h39);
        check("pin_crc_check", c, 32'hCBF43926);

        // IEND: three words, CRC AE426082.
        base_x = xfer_cnt;
        run_chunk(32'h49454E44, none, 0, -1);
        check("iend_words", 32'(xfer_cnt - base_x), 3);
        check("iend_last_crc", prev_dat, 32'hAE426082);

        d = '{32'h04090409};
        run_chunk(32'h49444154, d, 0, -1);

        d = '{32'h11223344, 32'hA5A55A5A, 32'hCAFEF00D};
        run_chunk(32'h49444154, d, 0, -1);
        rdy_mode = 1;
        run_chunk(32'h49444154, d, 1, -1);
        rdy_mode = 0;

        // Bad length.
        base_err = err_cnt; base_start = crc_start_cnt; base_val = val_cnt;
        bus.start_i = 1'b1;
        bus.len_i = 32'd13;
        bus.typ_i = 32'h49444154;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bad_len_start_rdy", 32'(bus.start_rdy_o), 1);
            @(posedge clk); #1;
        end
        check("bad_len_err_pulse", 32'(err_cnt - base_err), 1);
        check("bad_len_crc_start", 32'(crc_start_cnt - base_start), 0);
        check("bad_len_val", 32'(val_cnt - base_val), 0);

        // Reset mid-DAT, then IEND recovers.
        run_chunk(32'h49444154, d, 0, 1);
        run_chunk(32'h49454E44, none, 0, -1);
        check("post_abort_crc", prev_dat, 32'hAE426082);

        // Back-to-back IEND with start_i held.
        push_chunk(32'h49454E44, none);
        push_chunk(32'h49454E44, none);
        base_start = start_acc_cnt; base_x = xfer_cnt; base_l = lst_cnt;
        bus.start_i = 1'b1;
        bus.len_i = '0;
        bus.typ_i = 32'h49454E44;
        guard = 0;
        while (start_acc_cnt < base_start + 2 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.start_i = 1'b0;
        check("b2b_timeout", 32'(guard < 200), 1);
        check("b2b_gap", 32'(start_gap), 1);
        wait_drain();
        check("b2b_words", 32'(xfer_cnt - base_x), 6);
        check("b2b_lst", 32'(lst_cnt - base_l), 2);

        // Random chunks under random backpressure.
        rdy_mode = 2;
        for (int n = 0; n < 20; n++) begin
            d.delete();
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) d.push_back($urandom);
            run_chunk($urandom, d, 1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
